key_event: RTL

- Downstream consumer of the glitch/debounce filter output. Takes the filtered, clean key level and classifies it into single-cycle event pulses: press, release, short click, double click, long press and auto-repeat.
- Feeds the control/register layer, which counts or acts on events. It never sees raw input.

---
 rtl/key_event_pkg.sv | 17 +
 rtl/key_event_timer.sv | 23 ++
 rtl/key_event.sv | 91 +++++++++
 3 files changed

// File: rtl/key_event_pkg.sv
// key_event_pkg: shared state encoding and event-vector bit positions for the key classifier
package key_event_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DOWN1 = 3'd1,
    UP1   = 3'd2,
    DOWN2 = 3'd3,
    LONG  = 3'd4
  } state_t;
  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_CLICK   = 2;
  localparam int EV_DBL     = 3;
  localparam int EV_LONG    = 4;
  localparam int EV_RPT     = 5;
  localparam int EV_W       = 6;
endpackage

// File: rtl/key_event_timer.sv
// key_event_timer: saturating cycle counter with terminal compares for hold, gap and repeat periods
module key_event_timer #(
  parameter int LONG_CYC   = 16,
  parameter int DBL_GAP    = 12,
  parameter int REPEAT_CYC = 8,
  parameter int CNT_W      = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic long_end,
  output logic dbl_end,
  output logic rpt_end
);
  logic [CNT_W-1:0] cnt;
  // count up from the last clear, holding at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? '0 : cnt + CNT_W'(~&cnt);
  assign long_end = cnt == CNT_W'(LONG_CYC - 1);
  assign dbl_end  = cnt == CNT_W'(DBL_GAP - 1);
  assign rpt_end  = (REPEAT_CYC != 0) && (cnt == CNT_W'(REPEAT_CYC - 1));
endmodule

// File: rtl/key_event.sv
// key_event: classifies a clean key level into press/release/click/double/long/repeat pulses
module key_event
  import key_event_pkg::*;
#(
  parameter int LONG_CYC   = 16,
  parameter int DBL_GAP    = 12,
  parameter int REPEAT_CYC = 8,
  parameter int CNT_W      = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic press,
  output logic rel,
  output logic click,
  output logic dbl,
  output logic long_press,
  output logic rpt,
  output logic busy
);
  if ((1 << CNT_W) < LONG_CYC || (1 << CNT_W) < DBL_GAP || (1 << CNT_W) < REPEAT_CYC ||
      LONG_CYC < 2 || DBL_GAP < 1) begin : g_bad_params
    $error("key_event: illegal LONG_CYC/DBL_GAP/REPEAT_CYC/CNT_W combination");
  end
  state_t state, state_n;
  logic [EV_W-1:0] ev, ev_n;
  logic hold, clr, long_end, dbl_end, rpt_end;
  // a rpt pulse restarts the repeat period without leaving LONG; disable also zeroes the count
  assign clr = (state_n != state) || ev_n[EV_RPT] || !en;
  key_event_timer #(
    .LONG_CYC(LONG_CYC), .DBL_GAP(DBL_GAP), .REPEAT_CYC(REPEAT_CYC), .CNT_W(CNT_W)
  ) u_timer (
    .clk(clk), .rst(rst), .clr(clr),
    .long_end(long_end), .dbl_end(dbl_end), .rpt_end(rpt_end)
  );
  // next state: a din change always beats counter expiry; hold blocks a key still down from a disable
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = din && !hold ? DOWN1 : IDLE;
      DOWN1:   state_n = !din ? UP1 : long_end ? LONG : DOWN1;
      UP1:     state_n = din ? DOWN2 : dbl_end ? IDLE : UP1;
      DOWN2:   state_n = !din ? IDLE : long_end ? LONG : DOWN2;
      LONG:    state_n = !din ? IDLE : LONG;
      default: state_n = IDLE;
    endcase
    if (!en) state_n = IDLE;
  end
  // pulses that accompany the transition taken on this edge
  always_comb begin
    ev_n = '0;
    if (en)
      case (state)
        IDLE:    ev_n[EV_PRESS] = din && !hold;
        DOWN1, DOWN2: begin
          ev_n[EV_RELEASE] = !din;
          ev_n[EV_LONG]    = din && long_end;
        end
        UP1: begin
          ev_n[EV_PRESS] = din;
          ev_n[EV_DBL]   = din;
          ev_n[EV_CLICK] = !din && dbl_end;
        end
        LONG: begin
          ev_n[EV_RELEASE] = !din;
          ev_n[EV_RPT]     = din && rpt_end;
        end
        default: ev_n = '0;
      endcase
  end
  // state, pulse and busy registers; hold remembers a key that was down while disabled
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ev    <= '0;
      busy  <= 1'b0;
      hold  <= 1'b0;
    end else begin
      state <= state_n;
      ev    <= ev_n;
      busy  <= state_n != IDLE;
      hold  <= en ? hold && din : din;
    end
  assign press      = ev[EV_PRESS];
  assign rel        = ev[EV_RELEASE];
  assign click      = ev[EV_CLICK];
  assign dbl        = ev[EV_DBL];
  assign long_press = ev[EV_LONG];
  assign rpt        = ev[EV_RPT];
endmodule
